// File: rtl/adat_pkg.sv
// Shared types and frame-period thresholds for the ADAT receive output stage.
package adat_pkg;

  typedef enum logic [2:0] {
    SampleRate_Unknown     = 3'd0,
    SampleRate_Rate44_1kHz = 3'd1,
    SampleRate_Rate48kHz   = 3'd2,
    SampleRate_Rate88_2kHz = 3'd3,
    SampleRate_Rate96kHz   = 3'd4
  } SampleRate;

  localparam int unsigned FRAME_TIME_W = 12;
  localparam int unsigned DATA_W       = 24;
  localparam int unsigned NUM_CH       = 8;

  // Inclusive frame-period windows, in system clock cycles.
  localparam logic [FRAME_TIME_W-1:0] FT_48K_MIN = 12'd1900;
  localparam logic [FRAME_TIME_W-1:0] FT_48K_MAX = 12'd2175;
  localparam logic [FRAME_TIME_W-1:0] FT_44K_MIN = 12'd2176;
  localparam logic [FRAME_TIME_W-1:0] FT_44K_MAX = 12'd2450;

  localparam logic [3:0] VALID_CH_NORMAL = 4'd8;
  localparam logic [3:0] VALID_CH_SMUX2  = 4'd4;

endpackage

// File: rtl/output_interface_rate_classifier.sv
// Combinational sample-rate classifier: frame period window plus S/MUX2 doubling.
module rate_classifier
  import adat_pkg::*;
(
  input  logic [FRAME_TIME_W-1:0] frame_time_i,
  input  logic                    smux2_i,
  output SampleRate               rate_o
);

  always_comb begin
    rate_o = SampleRate_Unknown;
    if (frame_time_i >= FT_48K_MIN && frame_time_i <= FT_48K_MAX) begin
      rate_o = smux2_i ? SampleRate_Rate96kHz : SampleRate_Rate48kHz;
    end else if (frame_time_i >= FT_44K_MIN && frame_time_i <= FT_44K_MAX) begin
      rate_o = smux2_i ? SampleRate_Rate88_2kHz : SampleRate_Rate44_1kHz;
    end
  end

endmodule

// File: rtl/output_interface.sv
// ADAT output stage: channel bank capture, frame strobe, rate/lock tracking and word clock.
module output_interface
  import adat_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [FRAME_TIME_W-1:0] i_frame_time,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [2:0]              i_channel,
  input  logic                    i_data_valid,
  input  logic                    i_sync,
  input  logic [3:0]              i_user_bits,
  output SampleRate               o_sample_rate,
  output logic                    o_word_clk,
  output logic [DATA_W-1:0]       o_channels [0:NUM_CH-1],
  output logic                    o_valid,
  output logic                    o_locked,
  output logic [3:0]              o_valid_channels
);

  logic [DATA_W-1:0] chan_q [0:NUM_CH-1];
  SampleRate         rate_q, rate_d;
  logic [1:0]        good_cnt_q, good_cnt_d;
  logic              locked_q, locked_d;
  logic              wclk_q, wclk_d;
  logic              smux_q, smux_d;
  logic [3:0]        vch_q, vch_d;

  SampleRate         rate_class;
  logic              frame_done;
  logic              frame_good;

  rate_classifier u_rate_classifier (
    .frame_time_i (i_frame_time),
    .smux2_i      (i_user_bits[1]),
    .rate_o       (rate_class)
  );

  assign frame_done = i_data_valid && (i_channel == 3'd7);
  assign frame_good = i_sync && (rate_class != SampleRate_Unknown);

  always_comb begin
    rate_d     = rate_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    smux_d     = smux_q;
    vch_d      = vch_q;
    if (frame_done) begin
      smux_d = i_user_bits[1];
      vch_d  = i_user_bits[1] ? VALID_CH_SMUX2 : VALID_CH_NORMAL;
      if (frame_good) begin
        rate_d     = rate_class;
        good_cnt_d = (good_cnt_q == 2'd3) ? 2'd3 : good_cnt_q + 2'd1;
        locked_d   = (good_cnt_d >= 2'd2);
      end else begin
        rate_d     = SampleRate_Unknown;
        good_cnt_d = 2'd0;
        locked_d   = 1'b0;
      end
    end
  end

  // Word clock follows the mode latched at the previous frame completion.
  always_comb begin
    wclk_d = wclk_q;
    if (i_data_valid) begin
      if (smux_q) begin
        unique case (i_channel)
          3'd0, 3'd4: wclk_d = 1'b1;
          3'd2, 3'd6: wclk_d = 1'b0;
          default:    wclk_d = wclk_q;
        endcase
      end else begin
        unique case (i_channel)
          3'd0:    wclk_d = 1'b1;
          3'd4:    wclk_d = 1'b0;
          default: wclk_d = wclk_q;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rate_q     <= SampleRate_Unknown;
      good_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
      wclk_q     <= 1'b0;
      smux_q     <= 1'b0;
      vch_q      <= 4'd0;
    end else begin
      rate_q     <= rate_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      wclk_q     <= wclk_d;
      smux_q     <= smux_d;
      vch_q      <= vch_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        chan_q[k] <= '0;
      end
    end else if (i_data_valid) begin
      chan_q[i_channel] <= i_data;
    end
  end

  assign o_valid          = frame_done;
  assign o_sample_rate    = rate_q;
  assign o_locked         = locked_q;
  assign o_word_clk       = wclk_q;
  assign o_valid_channels = vch_q;
  assign o_channels       = chan_q;

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface with a frame-completion scoreboard.
module tb_output_interface;
  import adat_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [11:0] i_frame_time;
  logic [23:0] i_data;
  logic [2:0]  i_channel;
  logic        i_data_valid;
  logic        i_sync;
  logic [3:0]  i_user_bits;
  SampleRate   o_sample_rate;
  logic        o_word_clk;
  logic [23:0] o_channels [0:7];
  logic        o_valid;
  logic        o_locked;
  logic [3:0]  o_valid_channels;

  output_interface dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_frame_time     (i_frame_time),
    .i_data           (i_data),
    .i_channel        (i_channel),
    .i_data_valid     (i_data_valid),
    .i_sync           (i_sync),
    .i_user_bits      (i_user_bits),
    .o_sample_rate    (o_sample_rate),
    .o_word_clk       (o_word_clk),
    .o_channels       (o_channels),
    .o_valid          (o_valid),
    .o_locked         (o_locked),
    .o_valid_channels (o_valid_channels)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0] rate;
    logic       locked;
    logic [3:0] vch;
  } exp_t;

  exp_t        sb [$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          gc_m;
  logic        mode_m;
  logic        wclk_m;
  logic [23:0] bank_m [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_rate(input logic [11:0] ft, input logic smux);
    if (ft >= 12'd1900 && ft <= 12'd2175)
      return smux ? 3'd4 : 3'd2;
    else if (ft >= 12'd2176 && ft <= 12'd2450)
      return smux ? 3'd3 : 3'd1;
    return 3'd0;
  endfunction

  task automatic model_reset();
    gc_m   = 0;
    mode_m = 1'b0;
    wclk_m = 1'b0;
    for (int k = 0; k < 8; k++) bank_m[k] = 24'h0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rate"}, 32'(o_sample_rate), 32'd0);
    chk({tag, "_wclk"}, 32'(o_word_clk), 32'd0);
    chk({tag, "_lock"}, 32'(o_locked), 32'd0);
    chk({tag, "_vch"},  32'(o_valid_channels), 32'd0);
    for (int k = 0; k < 8; k++) chk({tag, "_chan"}, 32'(o_channels[k]), 32'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    i_data_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    check_reset_state("reset");
    i_rst = 1'b1;
  endtask

  // One captured word: drive after an edge, check o_valid mid-cycle, check registers after the edge.
  task automatic send_word(input logic [2:0] ch, input logic [23:0] d,
                           input logic [11:0] ft, input logic sync, input logic [3:0] ub);
    exp_t  e;
    logic  good;
    logic [2:0] r;
    i_channel    = ch;
    i_data       = d;
    i_data_valid = 1'b1;
    i_frame_time = ft;
    i_sync       = sync;
    i_user_bits  = ub;
    if (ch == 3'd7) begin
      r    = model_rate(ft, ub[1]);
      good = sync && (r != 3'd0);
      if (good) gc_m = (gc_m < 3) ? gc_m + 1 : 3;
      else      gc_m = 0;
      e.rate   = good ? r : 3'd0;
      e.locked = (gc_m >= 2);
      e.vch    = ub[1] ? 4'd4 : 4'd8;
      sb.push_back(e);
    end
    if (mode_m) begin
      if (ch == 3'd0 || ch == 3'd4) wclk_m = 1'b1;
      if (ch == 3'd2 || ch == 3'd6) wclk_m = 1'b0;
    end else begin
      if (ch == 3'd0) wclk_m = 1'b1;
      if (ch == 3'd4) wclk_m = 1'b0;
    end
    bank_m[ch] = d;
    @(negedge i_clk);
    chk("o_valid", 32'(o_valid), 32'(ch == 3'd7));
    @(posedge i_clk);
    #1;
    i_data_valid = 1'b0;
    chk("word_clk", 32'(o_word_clk), 32'(wclk_m));
    chk("chan_slot", 32'(o_channels[ch]), 32'(d));
    if (ch == 3'd7) begin
      mode_m = ub[1];
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rate",   32'(o_sample_rate), 32'(e.rate));
        chk("locked", 32'(o_locked), 32'(e.locked));
        chk("vch",    32'(o_valid_channels), 32'(e.vch));
      end
    end
  endtask

  task automatic send_frame(input logic [11:0] ft, input logic sync,
                            input logic [3:0] ub, input logic [7:0] mid);
    for (int ch = 0; ch < 8; ch++) send_word(3'(ch), {8'hAA, mid, 5'd0, 3'(ch)}, ft, sync, ub);
    for (int k = 0; k < 8; k++) chk("bank", 32'(o_channels[k]), 32'(bank_m[k]));
  endtask

  task automatic idle_cycle();
    i_data_valid = 1'b0;
    i_channel    = 3'd7;
    i_data       = 24'hDEAD01;
    @(negedge i_clk);
    chk("idle_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 8; k++) chk("idle_bank", 32'(o_channels[k]), 32'(bank_m[k]));
  endtask

  initial begin
    i_rst = 1'b0;
    i_frame_time = 12'd2048;
    i_data = '0;
    i_channel = '0;
    i_data_valid = 1'b0;
    i_sync = 1'b1;
    i_user_bits = 4'b0000;
    @(posedge i_clk);
    #1;
    do_reset();

    // Normal 48 kHz, five frames
    for (int f = 0; f < 5; f++) send_frame(12'd2048, 1'b1, 4'b0000, 8'h00);
    idle_cycle();

    // S/MUX2 96 kHz
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(12'd2048, 1'b1, 4'b0010, 8'(f + 1));

    // 44.1 / 88.2 and window edges
    send_frame(12'd2300, 1'b1, 4'b0000, 8'h11);
    send_frame(12'd2300, 1'b1, 4'b0010, 8'h12);
    send_frame(12'd1900, 1'b1, 4'b0000, 8'h13);
    send_frame(12'd2175, 1'b1, 4'b0000, 8'h14);
    send_frame(12'd2176, 1'b1, 4'b0000, 8'h15);
    send_frame(12'd2450, 1'b1, 4'b0000, 8'h16);
    send_frame(12'd1899, 1'b1, 4'b0000, 8'h17);
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h18);
    send_frame(12'd2451, 1'b1, 4'b0000, 8'h19);

    // Bad frames drop lock; relock after two good
    for (int f = 0; f < 3; f++) send_frame(12'd2048, 1'b1, 4'b0000, 8'h20);
    send_frame(12'd1000, 1'b1, 4'b0000, 8'h21);
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h22);
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h23);
    send_frame(12'd2048, 1'b0, 4'b0000, 8'h24);
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h25);
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h26);

    // Out-of-order overwrite
    send_word(3'd3, 24'h123456, 12'd2048, 1'b1, 4'b0000);
    send_word(3'd3, 24'h654321, 12'd2048, 1'b1, 4'b0000);

    // Reset mid-frame, then first frame strobes without lock
    for (int ch = 0; ch < 4; ch++) send_word(3'(ch), 24'h0F0F00 | 24'(ch), 12'd2048, 1'b1, 4'b0000);
    do_reset();
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h30);
    send_frame(12'd2048, 1'b1, 4'b0000, 8'h31);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
